p_alu_iq: RTL and testbench
===========================

Name: p_alu_iq

Overview:
- ALU issue queue: the receiving end of the dispatch-to-ALU handshake.
- Accepts up to two dispatched instructions per beat and holds them in an age-ordered compacting buffer.
- Captures missing source operands from the two CDB write-back ports.
- Issues the oldest instruction whose operands are both ready to one ALU, one per cycle, under valid/ready.

Parameters:
- DEPTH, 8, number of entries; must be at least 2.
- ROB_WIDTH, 6, physical-register/ROB tag width.
- OP_WIDTH, 8, ALU opcode width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assert, active-high.
- flush_i  input  1  synchronous pipeline flush.
- disp_valid_i  input  1  dispatch beat valid.
- disp_ready_o  output  1  queue can accept a full beat.
- disp_inst_valid_i  input  2  per-slot instruction valid within the beat.
- disp_op_i  input  2xOP_WIDTH  per-slot opcode.
- disp_preg_i  input  2xROB_WIDTH  per-slot destination tag.
- disp_src_preg_i  input  2x2xROB_WIDTH  per-slot source tags, index [slot][src].
- disp_src_data_i  input  2x2x32  per-slot source data, valid only where the matching ready bit is set.
- disp_src_rdy_i  input  2x2  source data already valid at dispatch.
- cdb_valid_i  input  2  CDB port valid.
- cdb_preg_i  input  2xROB_WIDTH  CDB tag.
- cdb_data_i  input  2x32  CDB data.
- iss_valid_o  output  1  issue candidate present.
- iss_ready_i  input  1  ALU accepts.
- iss_op_o  output  OP_WIDTH  opcode of the issued entry.
- iss_preg_o  output  ROB_WIDTH  destination tag of the issued entry.
- iss_src0_o  output  32  source 0 data.
- iss_src1_o  output  32  source 1 data.

Behaviour:
- Storage: DEPTH entries. Each entry holds valid, op, preg, two src tags, two src data words and two rdy bits.
- Ordering: entry 0 is always the oldest; valid entries are contiguous from index 0. A count register tracks occupancy in the range 0..DEPTH.
- Reset (rst high, asynchronous): all entry valid bits = 0, count = 0. Outputs go immediately to disp_ready_o = 1, iss_valid_o = 0, and all iss_* data = 0.
- Dispatch acceptance:
  - disp_ready_o = (count <= DEPTH-2). It is purely a function of registered count, with no combinational path from iss_ready_i or disp_valid_i.
  - A beat is accepted when disp_valid_i & disp_ready_o.
  - Slots with disp_inst_valid_i set are appended in slot order: slot 0 is older than slot 1.
  - A beat with inst_valid = 2'b10 appends only slot 1, into the first free position; no hole is left.
  - A beat with inst_valid = 2'b00 is accepted and changes nothing.
- Wakeup:
  - Each cycle, for every stored source with rdy = 0: if cdb_valid_i[j] and cdb_preg_i[j] equals that source tag, capture cdb_data_i[j] and set rdy at the next edge.
  - If both CDB ports match the same source, port 0 wins.
  - The same matching also applies to incoming dispatch sources with disp_src_rdy_i = 0 in the accept cycle, so no broadcast is missed.
- Select and issue:
  - iss_valid_o = 1 when any valid entry has both rdy bits set and flush_i = 0.
  - The issued entry is the lowest index with both rdy bits set. iss_* outputs are combinational from that entry; they are 0 when iss_valid_o = 0.
  - When iss_valid_o & iss_ready_i, the entry is removed at the edge and younger entries shift down one position.
- Latency:
  - An instruction dispatched fully ready at edge t can issue in cycle t+1.
  - A source woken by the CDB in cycle t makes its entry issuable in cycle t+1. There is no same-cycle wakeup-to-issue path.
- Simultaneous issue and dispatch in one cycle: compaction of the removed entry is applied first, then the new instructions are appended. count_next = count − issued + appended.
- Holding: while iss_valid_o = 1 and iss_ready_i = 0, the selected entry and iss_* outputs are held. A newly woken older entry may replace the candidate from the next cycle.
- Flush: flush_i = 1 clears all entries and sets count = 0 at the edge. Flush overrides a dispatch or issue in the same cycle: nothing is accepted or removed, and iss_valid_o is forced to 0.
- Full: at count = DEPTH-1 or DEPTH, disp_ready_o = 0, even if an issue is occurring in the same cycle.

Test Plan:
- Reset then dispatch 2 ready insts (pregs 3, 4; src data 0x11/0x22 and 0x33/0x44), iss_ready_i = 1 → preg 3 issues in the cycle after accept with src0 = 0x11, src1 = 0x22; preg 4 issues the next cycle; count returns to 0.
- Dispatch preg 5 with src1 tag 9 not ready; CDB port 1 broadcasts tag 9 with data 0xDEAD one cycle later → no issue in the broadcast cycle; next cycle iss_src1_o = 0xDEAD.
- Dispatch not-ready src tag 7 in the same cycle as CDB tag 7 with data 0x5A → entry stored ready; issues the next cycle with src = 0x5A.
- Fill DEPTH = 8 with not-ready insts → disp_ready_o = 0 at count 7. Wake entry 2 only → entry 2 issues, entries 3..6 shift down, disp_ready_o = 1 again at count 6.
- Both CDB ports broadcast tag 9 with data 0x1 and 0x2 to a waiting source → captured data = 0x1.
- flush_i high with disp_valid_i and iss_ready_i both high → nothing issued, count = 0 next cycle. Assert rst mid-queue → iss_valid_o drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/p_alu_iq_if.sv
// p_alu_iq_if: dispatch, CDB write-back and issue signals of the ALU issue queue.
//   master : dispatch stage, CDB and ALU (drives *_i, observes *_o)
//   slave  : the issue queue itself (observes *_i, drives *_o)
//   flush_i       synchronous pipeline flush
//   disp_*        two-slot dispatch beat with valid/ready
//   cdb_*         two write-back broadcast ports
//   iss_*         single issue port with valid/ready
interface p_alu_iq_if #(
    parameter int ROB_WIDTH = 6,
    parameter int OP_WIDTH  = 8
);
    logic                              flush_i;
    logic                              disp_valid_i;
    logic                              disp_ready_o;
    logic [1:0]                        disp_inst_valid_i;
    logic [1:0][OP_WIDTH-1:0]          disp_op_i;
    logic [1:0][ROB_WIDTH-1:0]         disp_preg_i;
    logic [1:0][1:0][ROB_WIDTH-1:0]    disp_src_preg_i;
    logic [1:0][1:0][31:0]             disp_src_data_i;
    logic [1:0][1:0]                   disp_src_rdy_i;
    logic [1:0]                        cdb_valid_i;
    logic [1:0][ROB_WIDTH-1:0]         cdb_preg_i;
    logic [1:0][31:0]                  cdb_data_i;
    logic                              iss_valid_o;
    logic                              iss_ready_i;
    logic [OP_WIDTH-1:0]               iss_op_o;
    logic [ROB_WIDTH-1:0]              iss_preg_o;
    logic [31:0]                       iss_src0_o;
    logic [31:0]                       iss_src1_o;

    modport master (
        output flush_i, disp_valid_i, disp_inst_valid_i, disp_op_i, disp_preg_i,
               disp_src_preg_i, disp_src_data_i, disp_src_rdy_i,
               cdb_valid_i, cdb_preg_i, cdb_data_i, iss_ready_i,
        input  disp_ready_o, iss_valid_o, iss_op_o, iss_preg_o, iss_src0_o, iss_src1_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_inst_valid_i, disp_op_i, disp_preg_i,
               disp_src_preg_i, disp_src_data_i, disp_src_rdy_i,
               cdb_valid_i, cdb_preg_i, cdb_data_i, iss_ready_i,
        output disp_ready_o, iss_valid_o, iss_op_o, iss_preg_o, iss_src0_o, iss_src1_o
    );
endinterface

// File: rtl/p_alu_iq.sv
// p_alu_iq: age-ordered compacting ALU issue queue.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : p_alu_iq_if slave modport (dispatch, CDB wakeup, issue)
// Entry 0 is the oldest and valid entries are contiguous from index 0.
// Each cycle the lowest-index entry with both sources ready is offered to
// the ALU; on acceptance the younger entries shift down and newly
// dispatched instructions are appended behind the survivors.
module p_alu_iq #(
    parameter int DEPTH     = 8,
    parameter int ROB_WIDTH = 6,
    parameter int OP_WIDTH  = 8
) (
    input logic        clk,
    input logic        rst,
    p_alu_iq_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                           valid;
        logic [OP_WIDTH-1:0]            op;
        logic [ROB_WIDTH-1:0]           preg;
        logic [1:0][ROB_WIDTH-1:0]      tag;
        logic [1:0][31:0]               data;
        logic [1:0]                     rdy;
    } entry_t;

    entry_t         ent_q [DEPTH];
    entry_t         ent_d [DEPTH];
    entry_t         wk_s  [DEPTH];
    entry_t         cmp_s [DEPTH];
    entry_t         new_s [2];
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [CW-1:0]  base_s;
    logic [CW-1:0]  pos1_s;
    logic [DEPTH-1:0] hit_s;
    logic [IW-1:0]  sel_s;
    logic           iss_valid_s;
    logic           issue_s;
    logic           accept_s;

    // Capture CDB data into not-ready sources; port 0 has priority over port 1.
    function automatic entry_t wake(
        input entry_t                    e,
        input logic [1:0]                cv,
        input logic [1:0][ROB_WIDTH-1:0] cp,
        input logic [1:0][31:0]          cd
    );
        entry_t r;
        r = e;
        for (int s = 0; s < 2; s++) begin
            if (e.valid && !e.rdy[s] && cv[0] && (cp[0] == e.tag[s])) begin
                r.rdy[s]  = 1'b1;
                r.data[s] = cd[0];
            end else if (e.valid && !e.rdy[s] && cv[1] && (cp[1] == e.tag[s])) begin
                r.rdy[s]  = 1'b1;
                r.data[s] = cd[1];
            end else begin
                r.rdy[s]  = e.rdy[s];
            end
        end
        return r;
    endfunction

    // Oldest-ready select: scanning down from the top leaves the lowest hit index.
    always_comb begin
        hit_s = '0;
        sel_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_s[i] = ent_q[i].valid & (&ent_q[i].rdy);
            sel_s    = hit_s[i] ? IW'(i) : sel_s;
        end
        iss_valid_s = (|hit_s) & ~bus.flush_i;
    end

    // Issue port: data of the selected entry, zero when nothing is offered.
    always_comb begin
        bus.iss_valid_o = iss_valid_s;
        if (iss_valid_s) begin
            bus.iss_op_o   = ent_q[sel_s].op;
            bus.iss_preg_o = ent_q[sel_s].preg;
            bus.iss_src0_o = ent_q[sel_s].data[0];
            bus.iss_src1_o = ent_q[sel_s].data[1];
        end else begin
            bus.iss_op_o   = '0;
            bus.iss_preg_o = '0;
            bus.iss_src0_o = 32'h0;
            bus.iss_src1_o = 32'h0;
        end
    end

    // Two free slots are required so a full beat always fits, regardless of issue.
    assign bus.disp_ready_o = (count_q <= CW'(DEPTH - 2));

    // Next state: wakeup, then compaction of the issued entry, then append.
    always_comb begin
        issue_s  = iss_valid_s & bus.iss_ready_i;
        accept_s = bus.disp_valid_i & bus.disp_ready_o & ~bus.flush_i;
        for (int i = 0; i < DEPTH; i++) begin
            wk_s[i] = wake(ent_q[i], bus.cdb_valid_i, bus.cdb_preg_i, bus.cdb_data_i);
        end
        for (int s = 0; s < 2; s++) begin
            new_s[s]       = '0;
            new_s[s].valid = 1'b1;
            new_s[s].op    = bus.disp_op_i[s];
            new_s[s].preg  = bus.disp_preg_i[s];
            new_s[s].tag   = bus.disp_src_preg_i[s];
            new_s[s].data  = bus.disp_src_data_i[s];
            new_s[s].rdy   = bus.disp_src_rdy_i[s];
            new_s[s]       = wake(new_s[s], bus.cdb_valid_i, bus.cdb_preg_i, bus.cdb_data_i);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            cmp_s[i] = (issue_s && (IW'(i) >= sel_s)) ? wk_s[i + 1] : wk_s[i];
        end
        cmp_s[DEPTH - 1] = issue_s ? entry_t'('0) : wk_s[DEPTH - 1];
        // Slot 1 lands directly behind slot 0 only when slot 0 is present.
        base_s = count_q - CW'(issue_s);
        pos1_s = base_s + CW'(bus.disp_inst_valid_i[0]);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = bus.flush_i ? entry_t'('0) :
                       (accept_s && bus.disp_inst_valid_i[0] && (CW'(i) == base_s)) ? new_s[0] :
                       (accept_s && bus.disp_inst_valid_i[1] && (CW'(i) == pos1_s)) ? new_s[1] :
                       cmp_s[i];
        end
        count_d = bus.flush_i ? '0 :
                  base_s + CW'(accept_s & bus.disp_inst_valid_i[0])
                         + CW'(accept_s & bus.disp_inst_valid_i[1]);
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule

// File: tb/tb_p_alu_iq.sv
// tb_p_alu_iq: directed scenarios plus randomized traffic for p_alu_iq,
// checked against a queue-based reference model of the issue queue.
module tb_p_alu_iq;
    localparam int DEPTH = 8;
    localparam int RW    = 6;
    localparam int OW    = 8;
    localparam int BW    = OW + RW + 64;

    typedef struct packed {
        logic [OW-1:0]         op;
        logic [RW-1:0]         preg;
        logic [1:0][RW-1:0]    tag;
        logic [1:0][31:0]      data;
        logic [1:0]            rdy;
    } m_ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    m_ent_t m_q[$];

    always #5 clk = ~clk;

    p_alu_iq_if #(.ROB_WIDTH(RW), .OP_WIDTH(OW)) ifc ();

    p_alu_iq #(.DEPTH(DEPTH), .ROB_WIDTH(RW), .OP_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    function automatic m_ent_t m_wake(m_ent_t e);
        for (int s = 0; s < 2; s++) begin
            if (!e.rdy[s]) begin
                if (ifc.cdb_valid_i[0] && ifc.cdb_preg_i[0] == e.tag[s]) begin
                    e.data[s] = ifc.cdb_data_i[0];
                    e.rdy[s]  = 1'b1;
                end else if (ifc.cdb_valid_i[1] && ifc.cdb_preg_i[1] == e.tag[s]) begin
                    e.data[s] = ifc.cdb_data_i[1];
                    e.rdy[s]  = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic m_pick(output bit found, output int idx);
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < m_q.size(); k++) begin
            if (!found && m_q[k].rdy == 2'b11) begin
                found = 1'b1;
                idx   = k;
            end
        end
    endtask

    task automatic model_step();
        bit     found;
        int     idx;
        bit     accept;
        m_ent_t n;
        if (ifc.flush_i) begin
            m_q.delete();
        end else begin
            m_pick(found, idx);
            accept = ifc.disp_valid_i && (m_q.size() <= DEPTH - 2);
            for (int k = 0; k < m_q.size(); k++) m_q[k] = m_wake(m_q[k]);
            if (found && ifc.iss_ready_i) m_q.delete(idx);
            for (int s = 0; s < 2; s++) begin
                if (accept && ifc.disp_inst_valid_i[s]) begin
                    n.op   = ifc.disp_op_i[s];
                    n.preg = ifc.disp_preg_i[s];
                    n.tag  = ifc.disp_src_preg_i[s];
                    n.data = ifc.disp_src_data_i[s];
                    n.rdy  = ifc.disp_src_rdy_i[s];
                    m_q.push_back(m_wake(n));
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.flush_i           = 1'b0;
        ifc.disp_valid_i      = 1'b0;
        ifc.disp_inst_valid_i = 2'b00;
        ifc.disp_op_i         = '0;
        ifc.disp_preg_i       = '0;
        ifc.disp_src_preg_i   = '0;
        ifc.disp_src_data_i   = '0;
        ifc.disp_src_rdy_i    = '0;
        ifc.cdb_valid_i       = 2'b00;
        ifc.cdb_preg_i        = '0;
        ifc.cdb_data_i        = '0;
    endtask

    task automatic set_slot(input int s, input logic [OW-1:0] op, input logic [RW-1:0] preg,
                            input logic [RW-1:0] t0, input logic [RW-1:0] t1,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rdy);
        ifc.disp_op_i[s]          = op;
        ifc.disp_preg_i[s]        = preg;
        ifc.disp_src_preg_i[s][0] = t0;
        ifc.disp_src_preg_i[s][1] = t1;
        ifc.disp_src_data_i[s][0] = d0;
        ifc.disp_src_data_i[s][1] = d1;
        ifc.disp_src_rdy_i[s]     = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        ifc.iss_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ifc.disp_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ifc.disp_ready_o); else n_pass++;
        n_checks++; if (ifc.iss_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifc.iss_valid_o); else n_pass++;
        n_checks++; if ({ifc.iss_op_o, ifc.iss_preg_o, ifc.iss_src0_o, ifc.iss_src1_o} !== {BW{1'b0}})
            $display("FAIL reset_data: got %h want 0", {ifc.iss_op_o, ifc.iss_preg_o, ifc.iss_src0_o, ifc.iss_src1_o}); else n_pass++;
        m_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        set_slot(0, 8'h01, 6'd3, 6'd0, 6'd0, 32'h11, 32'h22, 2'b11);
        set_slot(1, 8'h02, 6'd4, 6'd0, 6'd0, 32'h33, 32'h44, 2'b11);
        ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b11; ifc.iss_ready_i = 1'b1;
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b0) $display("FAIL basic_empty: got %b want 0", ifc.iss_valid_o); else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b1 || ifc.iss_preg_o !== 6'd3) $display("FAIL basic_first: valid %b preg %0d want 1/3", ifc.iss_valid_o, ifc.iss_preg_o); else n_pass++;
        n_checks++; if (ifc.iss_src0_o !== 32'h11 || ifc.iss_src1_o !== 32'h22) $display("FAIL basic_src: got %h/%h want 11/22", ifc.iss_src0_o, ifc.iss_src1_o); else n_pass++;
        tick();
        n_checks++; if (ifc.iss_preg_o !== 6'd4 || ifc.iss_src0_o !== 32'h33 || ifc.iss_src1_o !== 32'h44)
            $display("FAIL basic_second: preg %0d src %h/%h want 4 33/44", ifc.iss_preg_o, ifc.iss_src0_o, ifc.iss_src1_o); else n_pass++;
        tick();
        n_checks++; if (ifc.iss_valid_o !== 1'b0 || ifc.disp_ready_o !== 1'b1) $display("FAIL basic_drain: valid %b ready %b want 0/1", ifc.iss_valid_o, ifc.disp_ready_o); else n_pass++;
    endtask

    task automatic test_wakeup();
        set_slot(0, 8'h05, 6'd5, 6'd0, 6'd9, 32'h1, 32'h0, 2'b01);
        ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b01; ifc.iss_ready_i = 1'b1;
        tick();
        clear_inputs();
        ifc.cdb_valid_i = 2'b10; ifc.cdb_preg_i[1] = 6'd9; ifc.cdb_data_i[1] = 32'hDEAD;
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b0) $display("FAIL wake_same_cycle: got %b want 0", ifc.iss_valid_o); else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b1 || ifc.iss_preg_o !== 6'd5 || ifc.iss_src1_o !== 32'hDEAD)
            $display("FAIL wake_issue: valid %b preg %0d src1 %h want 1/5/dead", ifc.iss_valid_o, ifc.iss_preg_o, ifc.iss_src1_o); else n_pass++;
        tick();
    endtask

    task automatic test_disp_wake();
        set_slot(0, 8'h06, 6'd6, 6'd7, 6'd0, 32'h0, 32'h3, 2'b10);
        ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b01; ifc.iss_ready_i = 1'b1;
        ifc.cdb_valid_i = 2'b01; ifc.cdb_preg_i[0] = 6'd7; ifc.cdb_data_i[0] = 32'h5A;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b1 || ifc.iss_preg_o !== 6'd6 || ifc.iss_src0_o !== 32'h5A)
            $display("FAIL disp_wake: valid %b preg %0d src0 %h want 1/6/5a", ifc.iss_valid_o, ifc.iss_preg_o, ifc.iss_src0_o); else n_pass++;
        tick();
    endtask

    task automatic test_full();
        ifc.iss_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            set_slot(0, 8'h10, RW'(10 + 2 * b), RW'(32 + 2 * b), 6'd0, 32'h0, 32'(2 * b), 2'b10);
            set_slot(1, 8'h11, RW'(11 + 2 * b), RW'(33 + 2 * b), 6'd0, 32'h0, 32'(2 * b + 1), 2'b10);
            ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b11;
            tick();
        end
        set_slot(0, 8'hEE, 6'd63, 6'd62, 6'd0, 32'h0, 32'h0, 2'b11);
        set_slot(1, 8'h12, 6'd16, 6'd38, 6'd0, 32'h0, 32'h6, 2'b10);
        ifc.disp_inst_valid_i = 2'b10;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.disp_ready_o !== 1'b0) $display("FAIL full_ready7: got %b want 0", ifc.disp_ready_o); else n_pass++;
        ifc.cdb_valid_i = 2'b01; ifc.cdb_preg_i[0] = 6'd34; ifc.cdb_data_i[0] = 32'hAB;
        ifc.iss_ready_i = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b1 || ifc.iss_preg_o !== 6'd12 || ifc.iss_src0_o !== 32'hAB)
            $display("FAIL full_wake2: valid %b preg %0d src0 %h want 1/12/ab", ifc.iss_valid_o, ifc.iss_preg_o, ifc.iss_src0_o); else n_pass++;
        n_checks++; if (ifc.disp_ready_o !== 1'b0) $display("FAIL full_ready_issuing: got %b want 0", ifc.disp_ready_o); else n_pass++;
        tick();
        n_checks++; if (ifc.disp_ready_o !== 1'b1 || ifc.iss_valid_o !== 1'b0) $display("FAIL full_ready6: ready %b valid %b want 1/0", ifc.disp_ready_o, ifc.iss_valid_o); else n_pass++;
        ifc.cdb_valid_i = 2'b11; ifc.cdb_preg_i[0] = 6'd38; ifc.cdb_preg_i[1] = 6'd35;
        ifc.cdb_data_i[0] = 32'hC6; ifc.cdb_data_i[1] = 32'hC3;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_preg_o !== 6'd13 || ifc.iss_src0_o !== 32'hC3) $display("FAIL full_shift_a: preg %0d src0 %h want 13/c3", ifc.iss_preg_o, ifc.iss_src0_o); else n_pass++;
        tick();
        n_checks++; if (ifc.iss_preg_o !== 6'd16 || ifc.iss_src1_o !== 32'h6) $display("FAIL full_shift_b: preg %0d src1 %h want 16/6", ifc.iss_preg_o, ifc.iss_src1_o); else n_pass++;
        ifc.flush_i = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_cdb_priority();
        set_slot(0, 8'h07, 6'd7, 6'd9, 6'd0, 32'h0, 32'h77, 2'b10);
        ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b01; ifc.iss_ready_i = 1'b0;
        tick();
        clear_inputs();
        ifc.cdb_valid_i = 2'b11; ifc.cdb_preg_i[0] = 6'd9; ifc.cdb_preg_i[1] = 6'd9;
        ifc.cdb_data_i[0] = 32'h1; ifc.cdb_data_i[1] = 32'h2;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b1 || ifc.iss_src0_o !== 32'h1) $display("FAIL cdb_prio: valid %b src0 %h want 1/1", ifc.iss_valid_o, ifc.iss_src0_o); else n_pass++;
        ifc.iss_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        set_slot(0, 8'h20, 6'd20, 6'd0, 6'd0, 32'h1, 32'h2, 2'b11);
        set_slot(1, 8'h21, 6'd21, 6'd0, 6'd0, 32'h3, 32'h4, 2'b11);
        ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b11; ifc.iss_ready_i = 1'b0;
        tick();
        set_slot(0, 8'h22, 6'd22, 6'd0, 6'd0, 32'h5, 32'h6, 2'b11);
        set_slot(1, 8'h23, 6'd23, 6'd0, 6'd0, 32'h7, 32'h8, 2'b11);
        ifc.flush_i = 1'b1; ifc.iss_ready_i = 1'b1;
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b0 || ifc.iss_preg_o !== 6'd0) $display("FAIL flush_forced: valid %b preg %0d want 0/0", ifc.iss_valid_o, ifc.iss_preg_o); else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b0 || ifc.disp_ready_o !== 1'b1) $display("FAIL flush_empty: valid %b ready %b want 0/1", ifc.iss_valid_o, ifc.disp_ready_o); else n_pass++;
    endtask

    task automatic test_rst_mid();
        set_slot(0, 8'h24, 6'd24, 6'd0, 6'd0, 32'h9, 32'hA, 2'b11);
        set_slot(1, 8'h25, 6'd25, 6'd0, 6'd0, 32'hB, 32'hC, 2'b11);
        ifc.disp_valid_i = 1'b1; ifc.disp_inst_valid_i = 2'b11; ifc.iss_ready_i = 1'b0;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b1 || ifc.iss_preg_o !== 6'd24) $display("FAIL rst_pre: valid %b preg %0d want 1/24", ifc.iss_valid_o, ifc.iss_preg_o); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (ifc.iss_valid_o !== 1'b0 || ifc.iss_preg_o !== 6'd0 || ifc.disp_ready_o !== 1'b1)
            $display("FAIL rst_async: valid %b preg %0d ready %b want 0/0/1", ifc.iss_valid_o, ifc.iss_preg_o, ifc.disp_ready_o); else n_pass++;
        m_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        bit              found;
        int              idx;
        logic            exp_v;
        logic            exp_r;
        logic [BW-1:0]   exp_bus;
        logic [BW-1:0]   got_bus;
        for (int c = 0; c < 800; c++) begin
            ifc.disp_valid_i      = 1'($urandom_range(0, 1));
            ifc.disp_inst_valid_i = 2'($urandom_range(0, 3));
            for (int s = 0; s < 2; s++) begin
                ifc.disp_op_i[s]   = OW'($urandom);
                ifc.disp_preg_i[s] = RW'($urandom);
                for (int r = 0; r < 2; r++) begin
                    ifc.disp_src_preg_i[s][r] = RW'($urandom_range(0, 7));
                    ifc.disp_src_data_i[s][r] = $urandom;
                end
                ifc.disp_src_rdy_i[s] = 2'($urandom_range(0, 3));
                ifc.cdb_preg_i[s]     = RW'($urandom_range(0, 7));
                ifc.cdb_data_i[s]     = $urandom;
            end
            ifc.cdb_valid_i = 2'($urandom_range(0, 3));
            ifc.iss_ready_i = ($urandom_range(0, 3) != 0);
            ifc.flush_i     = ($urandom_range(0, 39) == 0);
            #1;
            m_pick(found, idx);
            exp_v   = found && !ifc.flush_i;
            exp_r   = (m_q.size() <= DEPTH - 2);
            exp_bus = exp_v ? {m_q[idx].op, m_q[idx].preg, m_q[idx].data[0], m_q[idx].data[1]} : {BW{1'b0}};
            got_bus = {ifc.iss_op_o, ifc.iss_preg_o, ifc.iss_src0_o, ifc.iss_src1_o};
            n_checks++; if (ifc.iss_valid_o !== exp_v) $display("FAIL rand_valid c%0d: got %b want %b", c, ifc.iss_valid_o, exp_v); else n_pass++;
            n_checks++; if (ifc.disp_ready_o !== exp_r) $display("FAIL rand_ready c%0d: got %b want %b", c, ifc.disp_ready_o, exp_r); else n_pass++;
            n_checks++; if (got_bus !== exp_bus) $display("FAIL rand_data c%0d: got %h want %h", c, got_bus, exp_bus); else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        ifc.iss_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_wakeup();
        test_disp_wake();
        test_full();
        test_cdb_priority();
        test_flush();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
